// File: rtl/q_adapt_serial_pkg.sv
// Shared fixed-point constants and the q_adapt_serial FSM encoding.
package q_adapt_serial_pkg;

  localparam int unsigned FXP_N    = 16;
  localparam int unsigned FXP_FRAC = 8;

  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [ST_W-1:0] ST_SQ     = 2'd1;
  localparam logic [ST_W-1:0] ST_REDUCE = 2'd2;
  localparam logic [ST_W-1:0] ST_UPDATE = 2'd3;

endpackage

// File: rtl/fxp_mul.sv
// Signed fixed-point multiply with a full-precision 2N-bit product.
module fxp_mul #(
  parameter int unsigned N = 16
) (
  input  logic signed [N-1:0]   i_a,
  input  logic signed [N-1:0]   i_b,
  output logic signed [2*N-1:0] o_p
);

  assign o_p = i_a * i_b;

endmodule

// File: rtl/fxp_sat.sv
// Signed saturation of an IW-bit value into OW bits.
module fxp_sat #(
  parameter int unsigned IW = 17,
  parameter int unsigned OW = 16
) (
  input  logic [IW-1:0] i_x,
  output logic [OW-1:0] o_y
);

  // Value fits when every bit from the output sign bit upward agrees.
  logic [IW-OW:0] w_hi;
  assign w_hi = i_x[IW-1:OW-1];

  always_comb begin
    if ((&w_hi) || !(|w_hi)) o_y = i_x[OW-1:0];
    else if (i_x[IW-1])      o_y = {1'b1, {(OW-1){1'b0}}};
    else                     o_y = {1'b0, {(OW-1){1'b1}}};
  end

endmodule

// File: rtl/fxp_sub.sv
// Signed fixed-point subtract with a full-precision N+1-bit result.
module fxp_sub #(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N:0]   o_d
);

  assign o_d = {i_a[N-1], i_a} - {i_b[N-1], i_b};

endmodule

// File: rtl/q_adapt_serial.sv
// Serial adaptive process-noise estimator: one squared difference per cycle,
// reduced to an isotropic or per-axis diagonal, optionally exponentially smoothed.
module q_adapt_serial
  import q_adapt_serial_pkg::*;
#(
  parameter int unsigned N        = FXP_N,
  parameter int unsigned FRAC     = FXP_FRAC,
  parameter int unsigned DIM      = 2,
  parameter int unsigned ALPHA_SH = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   clr,
  input  logic                   mode,
  input  logic [DIM*N-1:0]       x_now,
  input  logic [DIM*N-1:0]       x_prev,
  output logic                   busy,
  output logic                   done,
  output logic [DIM*DIM*N-1:0]   q_flat
);

  localparam int unsigned L  = $clog2(DIM);
  localparam int unsigned AW = N + L;

  logic [ST_W-1:0]  r_state;
  logic [L-1:0]     r_idx;
  logic [DIM*N-1:0] r_now;
  logic [DIM*N-1:0] r_prev;
  logic             r_mode;
  logic [AW-1:0]    r_acc;
  logic             r_first;
  logic             r_done;
  logic [N-1:0]     r_sq   [DIM];
  logic [N-1:0]     r_meas [DIM];
  logic [N-1:0]     r_diag [DIM];

  logic [ST_W-1:0]      w_state_nxt;
  logic                 w_last;
  logic [N-1:0]         w_now_i;
  logic [N-1:0]         w_prev_i;
  logic [N:0]           w_diff;
  logic [N-1:0]         w_d;
  logic signed [2*N-1:0] w_prod;
  logic signed [2*N-1:0] w_prod_sh;
  logic [N-1:0]         w_sq;
  logic [N-1:0]         w_smooth [DIM];

  assign w_now_i  = r_now[r_idx*N +: N];
  assign w_prev_i = r_prev[r_idx*N +: N];
  assign w_last   = (r_idx == L'(DIM - 1));

  fxp_sub #(.N(N)) u_sub (.i_a(w_now_i), .i_b(w_prev_i), .o_d(w_diff));
  fxp_sat #(.IW(N + 1), .OW(N)) u_sat_diff (.i_x(w_diff), .o_y(w_d));
  fxp_mul #(.N(N)) u_mul (.i_a(w_d), .i_b(w_d), .o_p(w_prod));

  assign w_prod_sh = w_prod >>> FRAC;
  fxp_sat #(.IW(2 * N), .OW(N)) u_sat_sq (.i_x(w_prod_sh), .o_y(w_sq));

  for (genvar g = 0; g < DIM; g++) begin : g_axis
    logic signed [N:0] w_delta;
    logic signed [N:0] w_step;
    logic signed [N:0] w_sum;
    assign w_delta = $signed({r_meas[g][N-1], r_meas[g]}) - $signed({r_diag[g][N-1], r_diag[g]});
    assign w_step  = w_delta >>> ALPHA_SH;
    assign w_sum   = $signed({r_diag[g][N-1], r_diag[g]}) + w_step;
    fxp_sat #(.IW(N + 1), .OW(N)) u_sat_smooth (.i_x(w_sum), .o_y(w_smooth[g]));

    for (genvar c = 0; c < DIM; c++) begin : g_col
      if (g == c) begin : g_diag
        assign q_flat[(g*DIM+c)*N +: N] = r_diag[g];
      end else begin : g_off
        assign q_flat[(g*DIM+c)*N +: N] = '0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clr) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (start) w_state_nxt = ST_SQ;
        ST_SQ:     if (w_last) w_state_nxt = ST_REDUCE;
        ST_REDUCE: w_state_nxt = ST_UPDATE;
        ST_UPDATE: w_state_nxt = ST_IDLE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_now   <= '0;
      r_prev  <= '0;
      r_mode  <= 1'b0;
      r_acc   <= '0;
      r_first <= 1'b0;
      r_done  <= 1'b0;
      for (int i = 0; i < DIM; i++) begin
        r_sq[i]   <= '0;
        r_meas[i] <= '0;
        r_diag[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      if (clr) begin
        r_first <= 1'b0;
        for (int i = 0; i < DIM; i++) r_diag[i] <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_now  <= x_now;
              r_prev <= x_prev;
              r_mode <= mode;
              r_idx  <= '0;
              r_acc  <= '0;
            end
          end
          ST_SQ: begin
            r_sq[r_idx] <= w_sq;
            r_acc       <= r_acc + AW'(w_sq);
            r_idx       <= r_idx + L'(1);
          end
          ST_REDUCE: begin
            // Isotropic mean: dropping the low L bits divides by DIM.
            for (int i = 0; i < DIM; i++) r_meas[i] <= r_mode ? r_sq[i] : r_acc[L +: N];
          end
          ST_UPDATE: begin
            for (int i = 0; i < DIM; i++) begin
              r_diag[i] <= ((ALPHA_SH == 0) || !r_first) ? r_meas[i] : w_smooth[i];
            end
            r_first <= 1'b1;
            r_done  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy = (r_state != ST_IDLE);
  assign done = r_done;

endmodule

// File: tb/tb_q_adapt_serial.sv
// Directed and random bench for q_adapt_serial (N=16, FRAC=8, DIM=2) with a done-driven scoreboard.
module tb_q_adapt_serial;

  localparam int unsigned DIM = 2;
  localparam int unsigned LAT = DIM + 2;

  typedef struct {
    logic [63:0] q;
    int unsigned cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start0;
  logic        start2;
  logic        clr;
  logic        mode;
  logic [31:0] x_now;
  logic [31:0] x_prev;
  logic        busy0;
  logic        done0;
  logic [63:0] q0;
  logic        busy2;
  logic        done2;
  logic [63:0] q2;

  int unsigned cyc;
  int unsigned checks;
  int unsigned errors;
  exp_t        sb0 [$];
  exp_t        sb2 [$];
  exp_t        e0;
  exp_t        e2;

  q_adapt_serial #(.N(16), .FRAC(8), .DIM(DIM), .ALPHA_SH(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .clr(clr), .mode(mode),
    .x_now(x_now), .x_prev(x_prev), .busy(busy0), .done(done0), .q_flat(q0)
  );

  q_adapt_serial #(.N(16), .FRAC(8), .DIM(DIM), .ALPHA_SH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .clr(clr), .mode(mode),
    .x_now(x_now), .x_prev(x_prev), .busy(busy2), .done(done2), .q_flat(q2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done0 === 1'b1) begin
      chk("done0_expected", 64'(sb0.size() != 0), 64'd1);
      if (sb0.size() != 0) begin
        e0 = sb0.pop_front();
        chk("q0_value", q0, e0.q);
        chk("q0_latency", 64'(cyc), 64'(e0.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done2 === 1'b1) begin
      chk("done2_expected", 64'(sb2.size() != 0), 64'd1);
      if (sb2.size() != 0) begin
        e2 = sb2.pop_front();
        chk("q2_value", q2, e2.q);
        chk("q2_latency", 64'(cyc), 64'(e2.cyc));
      end
    end
  end

  function automatic logic [15:0] sq_of(input logic [15:0] a, input logic [15:0] b);
    longint d;
    logic [15:0] r;
    d = longint'($signed(a)) - longint'($signed(b));
    if (d > 32767) d = 32767;
    if (d < -32768) d = -32768;
    d = (d * d) >>> 8;
    if (d > 32767) d = 32767;
    r = d[15:0];
    return r;
  endfunction

  // Caller is just past an active edge; start is sampled on the next one.
  task automatic issue(input int sel, input logic m, input logic [31:0] now,
                       input logic [31:0] prev, input logic [15:0] d0, input logic [15:0] d1,
                       input bit push);
    exp_t e;
    mode   = m;
    x_now  = now;
    x_prev = prev;
    e.q    = {d1, 32'h0, d0};
    e.cyc  = cyc + 1 + LAT;
    if (sel == 0) begin
      start0 = 1'b1;
      if (push) sb0.push_back(e);
    end else begin
      start2 = 1'b1;
      if (push) sb2.push_back(e);
    end
    @(posedge clk); #1;
    start0 = 1'b0;
    start2 = 1'b0;
    mode   = ~m;
    x_now  = $urandom;
    x_prev = $urandom;
  endtask

  task automatic settle();
    repeat (LAT + 2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] n0, n1, p0, p1, s0, s1, mean;
    logic        m;
    int unsigned sum;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start0 = 1'b0;
    start2 = 1'b0;
    clr    = 1'b0;
    mode   = 1'b0;
    x_now  = '0;
    x_prev = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_done", 64'(done0), 64'd0);
    chk("rst_q0", q0, 64'd0);
    chk("rst_q2", q2, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Isotropic mean of squares, with the busy window.
    issue(0, 1'b0, {16'h0100, 16'h0200}, 32'h0, 16'h0280, 16'h0280, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("busy_window", 64'(busy0), (k < 4) ? 64'd1 : 64'd0);
    end
    settle();

    issue(0, 1'b1, {16'h0100, 16'h0200}, 32'h0, 16'h0400, 16'h0100, 1'b1);
    settle();

    issue(0, 1'b1, {16'h0000, 16'h7FFF}, {16'h0000, 16'h8000}, 16'h7FFF, 16'h0000, 1'b1);
    settle();

    // Smoothing: first sample loads directly, second moves a quarter of the way.
    issue(2, 1'b0, {16'h0100, 16'h0200}, 32'h0, 16'h0280, 16'h0280, 1'b1);
    settle();
    issue(2, 1'b0, {16'h0055, 16'h1234}, {16'h0055, 16'h1234}, 16'h01E0, 16'h01E0, 1'b1);
    settle();

    // start held for two cycles: the second is ignored.
    mode   = 1'b1;
    x_now  = {16'h0100, 16'h0200};
    x_prev = 32'h0;
    start0 = 1'b1;
    sb0.push_back('{q: {16'h0100, 32'h0, 16'h0400}, cyc: cyc + 1 + LAT});
    @(posedge clk); #1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    #1;
    chk("done_window", 64'(done0), 64'd1);
    issue(0, 1'b0, {16'h0100, 16'h0200}, 32'h0, 16'h0280, 16'h0280, 1'b1);
    settle();

    // Synchronous clear during the second SQ cycle.
    issue(0, 1'b0, {16'h0100, 16'h0200}, 32'h0, 16'h0, 16'h0, 1'b0);
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_busy", 64'(busy0), 64'd0);
    chk("clr_q0", q0, 64'd0);
    chk("clr_q2", q2, 64'd0);
    clr    = 1'b1;
    start0 = 1'b1;
    start2 = 1'b1;
    @(posedge clk); #1;
    clr    = 1'b0;
    start0 = 1'b0;
    start2 = 1'b0;
    chk("clr_prio_busy0", 64'(busy0), 64'd0);
    chk("clr_prio_busy2", 64'(busy2), 64'd0);
    repeat (8) @(posedge clk);
    #1;

    // After clr the smoother reloads rather than blending from zero.
    issue(2, 1'b0, {16'h0100, 16'h0200}, 32'h0, 16'h0280, 16'h0280, 1'b1);
    settle();

    // Asynchronous reset mid-SQ.
    issue(0, 1'b1, {16'h0100, 16'h0200}, 32'h0, 16'h0400, 16'h0100, 1'b1);
    settle();
    issue(0, 1'b1, {16'h0100, 16'h0200}, 32'h0, 16'h0, 16'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy0), 64'd0);
    chk("arst_done", 64'(done0), 64'd0);
    chk("arst_q0", q0, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    for (int t = 0; t < 6; t++) begin
      n0 = 16'($urandom);
      n1 = 16'($urandom);
      p0 = 16'($urandom);
      p1 = 16'($urandom);
      m  = 1'($urandom);
      s0 = sq_of(n0, p0);
      s1 = sq_of(n1, p1);
      sum  = 32'(s0) + 32'(s1);
      mean = 16'(sum >> 1);
      if (m) issue(0, m, {n1, n0}, {p1, p0}, s0, s1, 1'b1);
      else   issue(0, m, {n1, n0}, {p1, p0}, mean, mean, 1'b1);
      settle();
    end

    repeat (4) @(posedge clk);
    #1;
    chk("sb0_drained", 64'(sb0.size()), 64'd0);
    chk("sb2_drained", 64'(sb2.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/q_adapt_serial.md
Q_ADAPT_SERIAL -- requirements
Module: q_adapt_serial

Interface
REQ-001 Parameter N, default FXP_N: fixed-point word width.
REQ-002 Parameter FRAC, default FXP_FRAC: fractional bits.
REQ-003 Parameter DIM, default 2: state components; power of two, 2..8.
REQ-004 Parameter ALPHA_SH, default 0: smoothing shift, 0..7; 0 disables smoothing.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  request one estimate; sampled only in IDLE.
REQ-008 clr  in  1  synchronous clear/abort.
REQ-009 mode  in  1  0 = isotropic diagonal (mean of squares), 1 = per-axis diagonal; sampled with start.
REQ-010 x_now  in  DIM*N  signed components, component i at bits [i*N +: N].
REQ-011 x_prev  in  DIM*N  signed previous components, same packing.
REQ-012 busy  out  1  high whenever FSM is not IDLE.
REQ-013 done  out  1  registered one-cycle pulse, coincident with first cycle of updated q_flat.
REQ-014 q_flat  out  DIM*DIM*N  signed Q matrix, row-major, element (r,c) at bits [(r*DIM+c)*N +: N].

Function
REQ-015 FSM states: IDLE, SQ, REDUCE, UPDATE; binary encoded.
REQ-016 IDLE: start=1 and clr=0 latches x_now, x_prev and mode into internal registers, clears index and accumulator, goes to SQ.
REQ-017 SQ: one component per cycle at index i: d = sat_N(now_i - prev_i) from the N+1-bit difference.
REQ-018 SQ: s_i = sat_N((d*d full 2N bits) >>> FRAC), stored per axis and added to an N+log2(DIM)-bit accumulator; i = DIM-1 goes to REDUCE.
REQ-019 REDUCE: measured vector m_i = s_i when mode=1; all m_i = accumulator >>> log2(DIM), truncated to N, when mode=0; goes to UPDATE.
REQ-020 UPDATE: diag_i = m_i when ALPHA_SH=0 or first-sample flag clear; otherwise diag_i = diag_i + ((m_i - diag_i) >>> ALPHA_SH), computed at N+1 bits then saturated to N; sets first-sample flag, pulses done, goes to IDLE.
REQ-021 Off-diagonal q_flat elements SHALL always be zero; diagonal (i,i) = diag_i.
REQ-022 Latency: done rises exactly DIM+2 rising edges after the edge that samples start.
REQ-023 start while busy is ignored, not queued.
REQ-024 start during the done cycle is accepted, giving back-to-back estimates every DIM+2 cycles.
REQ-025 Inputs may change freely after the start edge without affecting the result.
REQ-026 clr in any state: FSM to IDLE, diag_i to 0, first-sample flag cleared, no done; clr has priority over start.
REQ-027 Saturation clips to [-2^(N-1), 2^(N-1)-1]; squares clip at 2^(N-1)-1.

Reset
REQ-028 rst_n low asynchronously forces IDLE, busy=0, done=0, q_flat=0, accumulator, index, latched inputs and first-sample flag to 0.
REQ-029 Reset mid-operation discards the estimate in progress, with no done afterwards.

Structure
REQ-030 FSM state encoding and width constants SHALL live in the shared fixed-point header alongside FXP_N/FXP_FRAC.
REQ-031 Difference and square SHALL reuse the existing fxp_sub and fxp_mul primitives, one instance each, time-shared across components.
REQ-032 One new sub-module, fxp_sat, SHALL perform parametrised wide-to-N signed saturation and be instanced for difference, square and smoothing.

Verification (N=16, FRAC=8, DIM=2)
REQ-033 mode=0, ALPHA_SH=0, x_now=(0x0200,0x0100), x_prev=0, start -> done at edge 4, diag=0x0280, off-diag 0, busy high for 4 cycles.
REQ-034 Same inputs, mode=1 -> diag=(0x0400,0x0100).
REQ-035 ALPHA_SH=2, mode=0: first run as REQ-033 -> 0x0280; second run x_now=x_prev -> 0x01E0.
REQ-036 x_now=(0x7FFF,0), x_prev=(0x8000,0), mode=1 -> diff saturates, diag0=0x7FFF, diag1=0.
REQ-037 start pulsed at cycles 1 and 2 -> exactly one done; start in done cycle -> next done DIM+2 edges later.
REQ-038 clr at cycle 2 of SQ -> no done, q_flat=0; rst_n low mid-SQ -> all outputs 0 immediately, no done after release.
